// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control FSM for the add/sub/or ALU datapath.
// Sequences fetch, decode, execute, memory and write-back for the MIPS subset
// addu/add/subu/or/slt, ori, lw, sw, beq, j. Traps signed-add overflow and
// counts retired instructions.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   op, funct                   opcode / function fields from the IR
//   alu_zero/overflow/less_than ALU status (combinational, current cycle)
//   mem_ready                   memory completes the current access
//   alu_sel, alu_src_a/b        ALU operation and operand selects
//   ext_zero                    zero-extend the immediate
//   pc_we, ir_we, mem_re/we, reg_we  enables
//   pc_src, reg_dst, wb_sel     PC, destination and write-back selects
//   ovf_exc, illegal            one-cycle exception pulses
//   state, retired              debug state and retired-instruction count
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_less_than,
  input  logic        mem_ready,
  output logic [1:0]  alu_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_zero,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  pc_src,
  output logic        reg_dst,
  output logic [1:0]  wb_sel,
  output logic        ovf_exc,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WB = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_WB     = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  state_t cur, nxt;
  logic   ovf_pending;
  logic   lt_q;
  logic   is_r;
  logic   r_ok;
  logic   op_ok;
  logic   retire;

  assign is_r  = (op == OP_RTYPE);
  assign r_ok  = (funct == FN_ADD) || (funct == FN_ADDU) || (funct == FN_SUBU) ||
                 (funct == FN_OR)  || (funct == FN_SLT);
  assign op_ok = (is_r && r_ok) || (op == OP_ORI) || (op == OP_LW) ||
                 (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);

  // An instruction retires on its last cycle; trapped adds never do.
  assign retire = ((cur == S_WB) && !ovf_pending) || (cur == S_MEM_WB) ||
                  ((cur == S_MEM_WR) && mem_ready) || (cur == S_BRANCH) ||
                  (cur == S_JUMP);

  assign state = cur;

  // State, trap flag, slt flag and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= S_FETCH;
      ovf_pending <= 1'b0;
      lt_q        <= 1'b0;
      retired     <= 32'd0;
    end else begin
      cur <= nxt;
      if (cur == S_EXEC_R) begin
        ovf_pending <= (funct == FN_ADD) && alu_overflow;
        lt_q        <= alu_less_than;
      end else if (cur == S_WB) begin
        // Consumed here, so a following ori cannot inherit a stale trap.
        ovf_pending <= 1'b0;
      end
      if (retire) retired <= retired + 32'd1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        if (!op_ok)              nxt = S_FETCH;
        else if (is_r)           nxt = S_EXEC_R;
        else if (op == OP_ORI)   nxt = S_EXEC_I;
        else if (op == OP_BEQ)   nxt = S_BRANCH;
        else if (op == OP_J)     nxt = S_JUMP;
        else                     nxt = S_ADDR;
      end
      S_EXEC_R: nxt = S_WB;
      S_EXEC_I: nxt = S_WB;
      S_ADDR:   nxt = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) nxt = S_MEM_WB;
      S_MEM_WB: nxt = S_FETCH;
      S_MEM_WR: if (mem_ready) nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    alu_sel   = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    ext_zero  = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    pc_src    = 2'b00;
    reg_dst   = 1'b0;
    wb_sel    = 2'b00;
    ovf_exc   = 1'b0;
    illegal   = 1'b0;
    if (rst_n) begin
      case (cur)
        S_FETCH: begin
          mem_re    = 1'b1;
          alu_src_b = 2'b01;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          illegal   = !op_ok;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          if (funct == FN_SUBU || funct == FN_SLT) alu_sel = 2'b01;
          else if (funct == FN_OR)                alu_sel = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_zero  = 1'b1;
          alu_sel   = 2'b10;
        end
        S_WB: begin
          reg_dst = is_r;
          wb_sel  = (is_r && funct == FN_SLT) ? 2'b10 : 2'b00;
          reg_we  = !ovf_pending;
          ovf_exc = ovf_pending;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: mem_re = 1'b1;
        S_MEM_WB: begin
          reg_we = 1'b1;
          wb_sel = 2'b01;
        end
        S_MEM_WR: mem_we = 1'b1;
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_sel   = 2'b01;
          pc_src    = 2'b01;
          pc_we     = alu_zero;
        end
        S_JUMP: begin
          pc_src = 2'b10;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, funct;
  logic        alu_zero, alu_overflow, alu_less_than, mem_ready;
  logic [1:0]  alu_sel, alu_src_b, pc_src, wb_sel;
  logic        alu_src_a, ext_zero, pc_we, ir_we, mem_re, mem_we, reg_we;
  logic        reg_dst, ovf_exc, illegal;
  logic [3:0]  state;
  logic [31:0] retired;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_less_than(alu_less_than), .mem_ready(mem_ready),
    .alu_sel(alu_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re),
    .mem_we(mem_we), .reg_we(reg_we), .pc_src(pc_src), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .ovf_exc(ovf_exc), .illegal(illegal), .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] v;
    logic [31:0] r;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_cyc;
  logic [31:0] model_ret = 32'd0;
  logic [21:0] dutv;

  assign dutv = {state, alu_sel, alu_src_a, alu_src_b, ext_zero, pc_we, ir_we,
                 mem_re, mem_we, reg_we, pc_src, reg_dst, wb_sel, ovf_exc, illegal};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Output word in the same field order as dutv.
  function automatic logic [21:0] mk(int st, int sel, int a, int b, int ext, int pcwe,
                                     int irwe, int mre, int mwe, int rwe, int pcs,
                                     int rdst, int wbs, int ovf, int ill);
    return {4'(st), 2'(sel), 1'(a), 2'(b), 1'(ext), 1'(pcwe), 1'(irwe), 1'(mre),
            1'(mwe), 1'(rwe), 2'(pcs), 1'(rdst), 2'(wbs), 1'(ovf), 1'(ill)};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Drive one cycle's inputs, queue its expected outputs, advance one clock.
  task automatic cyc(input logic [21:0] v, input logic mr, input logic z,
                     input logic ov, input logic ret);
    exp_t e;
    mem_ready     = mr;
    alu_zero      = z;
    alu_overflow  = ov;
    alu_less_than = rb();
    e.v = v;
    e.r = model_ret;
    exp_q.push_back(e);
    n_cyc++;
    @(posedge clk);
    #1;
    if (ret) model_ret = model_ret + 32'd1;
  endtask

  // kinds: 0 addu 1 add 2 subu 3 or 4 slt 5 ori 6 lw 7 sw 8 beq 9 j
  //        10 illegal op, 11 R-type with unsupported funct
  task automatic run_instr(input int k, input int fst, input int mst,
                           input logic ov, input logic z);
    logic trap;
    int   sel;
    n_cyc = 0;
    funct = 6'($urandom);
    case (k)
      0: begin op = 6'b000000; funct = 6'b100001; end
      1: begin op = 6'b000000; funct = 6'b100000; end
      2: begin op = 6'b000000; funct = 6'b100011; end
      3: begin op = 6'b000000; funct = 6'b100101; end
      4: begin op = 6'b000000; funct = 6'b101010; end
      5: op = 6'b001101;
      6: op = 6'b100011;
      7: op = 6'b101011;
      8: op = 6'b000100;
      9: op = 6'b000010;
      10: op = 6'b111111;
      default: begin op = 6'b000000; funct = 6'b000000; end
    endcase
    for (int i = 0; i < fst; i++)
      cyc(mk(0,0,0,1,0,0,0,1,0,0,0,0,0,0,0), 1'b0, rb(), rb(), 1'b0);
    cyc(mk(0,0,0,1,0,1,1,1,0,0,0,0,0,0,0), 1'b1, rb(), rb(), 1'b0);
    cyc(mk(1,0,0,3,0,0,0,0,0,0,0,0,0,0,(k >= 10) ? 1 : 0), rb(), rb(), rb(), 1'b0);
    if (k <= 4) begin
      sel  = (k == 2 || k == 4) ? 1 : (k == 3) ? 2 : 0;
      trap = (k == 1) && ov;
      cyc(mk(2,sel,1,0,0,0,0,0,0,0,0,0,0,0,0), rb(), rb(), ov, 1'b0);
      cyc(mk(10,0,0,0,0,0,0,0,0,trap ? 0 : 1,0,1,(k == 4) ? 2 : 0,trap ? 1 : 0,0),
          rb(), rb(), rb(), !trap);
    end else if (k == 5) begin
      cyc(mk(3,2,1,2,1,0,0,0,0,0,0,0,0,0,0), rb(), rb(), rb(), 1'b0);
      cyc(mk(10,0,0,0,0,0,0,0,0,1,0,0,0,0,0), rb(), rb(), rb(), 1'b1);
    end else if (k == 6) begin
      cyc(mk(4,0,1,2,0,0,0,0,0,0,0,0,0,0,0), rb(), rb(), rb(), 1'b0);
      for (int i = 0; i < mst; i++)
        cyc(mk(5,0,0,0,0,0,0,1,0,0,0,0,0,0,0), 1'b0, rb(), rb(), 1'b0);
      cyc(mk(5,0,0,0,0,0,0,1,0,0,0,0,0,0,0), 1'b1, rb(), rb(), 1'b0);
      cyc(mk(6,0,0,0,0,0,0,0,0,1,0,0,1,0,0), rb(), rb(), rb(), 1'b1);
    end else if (k == 7) begin
      cyc(mk(4,0,1,2,0,0,0,0,0,0,0,0,0,0,0), rb(), rb(), rb(), 1'b0);
      for (int i = 0; i < mst; i++)
        cyc(mk(7,0,0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b0, rb(), rb(), 1'b0);
      cyc(mk(7,0,0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b1, rb(), rb(), 1'b1);
    end else if (k == 8) begin
      cyc(mk(8,1,1,0,0,z ? 1 : 0,0,0,0,0,1,0,0,0,0), rb(), z, rb(), 1'b1);
    end else if (k == 9) begin
      cyc(mk(9,0,0,0,0,1,0,0,0,0,2,0,0,0,0), rb(), rb(), rb(), 1'b1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("outs_state%0d", e.v[21:18]), {42'd0, dutv}, {42'd0, e.v});
      chk($sformatf("retired_state%0d", e.v[21:18]), {32'd0, retired}, {32'd0, e.r});
    end
  end

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; mem_ready = 1'b0;
    alu_zero = 1'b0; alu_overflow = 1'b0; alu_less_than = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      cyc(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), rb(), rb(), rb(), 1'b0);
    rst_n = 1'b1;

    // Directed cases with literal cycle counts and retired values.
    run_instr(0, 0, 0, 1'b0, 1'b0);
    chk("addu_cycles", 64'(n_cyc), 64'd4);
    chk("addu_retired", {32'd0, retired}, 64'd1);
    run_instr(1, 0, 0, 1'b1, 1'b0);
    chk("add_trap_cycles", 64'(n_cyc), 64'd4);
    chk("add_trap_retired", {32'd0, retired}, 64'd1);
    run_instr(5, 0, 0, 1'b0, 1'b0);
    chk("ori_after_trap_retired", {32'd0, retired}, 64'd2);
    run_instr(6, 0, 3, 1'b0, 1'b0);
    chk("lw_stall3_cycles", 64'(n_cyc), 64'd8);
    run_instr(8, 0, 0, 1'b0, 1'b1);
    chk("beq_taken_cycles", 64'(n_cyc), 64'd3);
    run_instr(8, 0, 0, 1'b0, 1'b0);
    chk("beq_not_taken_retired", {32'd0, retired}, 64'd5);
    run_instr(10, 0, 0, 1'b0, 1'b0);
    chk("illegal_cycles", 64'(n_cyc), 64'd2);
    chk("illegal_retired", {32'd0, retired}, 64'd5);
    run_instr(9, 0, 0, 1'b0, 1'b0);
    chk("j_cycles", 64'(n_cyc), 64'd3);
    run_instr(7, 0, 0, 1'b0, 1'b0);
    chk("sw_cycles", 64'(n_cyc), 64'd4);
    run_instr(4, 2, 0, 1'b0, 1'b0);
    chk("slt_fetch_stall2_cycles", 64'(n_cyc), 64'd6);
    chk("directed_retired", {32'd0, retired}, 64'd8);

    // Reset asserted while a store waits in MEM_WR.
    op = 6'b101011;
    cyc(mk(0,0,0,1,0,1,1,1,0,0,0,0,0,0,0), 1'b1, rb(), rb(), 1'b0);
    cyc(mk(1,0,0,3,0,0,0,0,0,0,0,0,0,0,0), rb(), rb(), rb(), 1'b0);
    cyc(mk(4,0,1,2,0,0,0,0,0,0,0,0,0,0,0), rb(), rb(), rb(), 1'b0);
    cyc(mk(7,0,0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b0, rb(), rb(), 1'b0);
    rst_n = 1'b0;
    model_ret = 32'd0;
    #1;
    chk("async_rst_state", {60'd0, state}, 64'd0);
    chk("async_rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("async_rst_retired", {32'd0, retired}, 64'd0);
    cyc(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0, rb(), rb(), 1'b0);
    rst_n = 1'b1;

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++)
      run_instr($urandom_range(0, 11), $urandom_range(0, 2), $urandom_range(0, 3),
                rb(), rb());

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control FSM that drives the 3-operation ALU (add/sub/or) in the p1 datapath and consumes its `zero`, `overflow_flag` and `less_than` status. It sequences fetch, decode, execute, memory and write-back for the supported MIPS subset. It produces every datapath enable and mux select, handles a memory wait handshake, and traps signed-add overflow. It also counts retired instructions.

## Interface
- No parameters. Encodings are fixed by the datapath.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: instruction[31:26], taken from the datapath IR.
- `funct` in 6: instruction[5:0], taken from the IR.
- `alu_zero`, `alu_overflow`, `alu_less_than` in 1 each: ALU status inputs, combinational in the current cycle.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `alu_sel` out 2: 00 add, 01 sub, 10 or.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2.
- `ext_zero` out 1: selects zero-extension of imm.
- `pc_we`, `ir_we`, `mem_re`, `mem_we`, `reg_we` out 1 each: write/read enables.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `wb_sel` out 2: 00 = ALUOut, 01 = MDR, 10 = zero-extended slt flag.
- `ovf_exc`, `illegal` out 1 each: one-cycle pulses.
- `state` out 4: current state, for debug.
- `retired` out 32: count of retired instructions.

## Operation
- Supported instructions:
  - R-type (op 000000): addu 100001, add 100000 (trapping), subu 100011, or 100101, slt 101010.
  - I-type and jumps: ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
- States: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, BRANCH 8, JUMP 9, WB 10.
- Outputs are Moore: decoded from the registered state, plus `op`/`funct` in EXEC_R/WB. Exception: `pc_we` and `ir_we` are qualified by `mem_ready` in FETCH, and `pc_we` by `alu_zero` in BRANCH.
- Every output not listed for a state is 0.
- FETCH:
  - Drives `mem_re`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_sel`=00, `pc_src`=00.
  - If `mem_ready`: `ir_we`=1, `pc_we`=1, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_sel`=00, which precomputes the branch target.
  - Next state by `op`: R → EXEC_R, ori → EXEC_I, lw/sw → ADDR, beq → BRANCH, j → JUMP.
  - Any other `op` (including R-type with an unlisted `funct`): pulse `illegal`, go to FETCH.
- EXEC_R:
  - Drives `alu_src_a`=1, `alu_src_b`=00.
  - `alu_sel` = 01 for subu/slt, 10 for or, 00 otherwise.
  - Latches `ovf_pending` = (funct==add) & `alu_overflow`, and `lt_q` = `alu_less_than`. Go to WB.
- EXEC_I: drives `alu_src_a`=1, `alu_src_b`=10, `ext_zero`=1, `alu_sel`=10. Go to WB.
- WB:
  - Drives `reg_dst` = 1 for R-type, 0 for ori.
  - `wb_sel` = 10 for slt, else 00.
  - `reg_we` = !`ovf_pending`. If `ovf_pending`: pulse `ovf_exc` and do not increment `retired`. Go to FETCH.
- ADDR: drives `alu_src_a`=1, `alu_src_b`=10, `ext_zero`=0, `alu_sel`=00. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: drives `mem_re`=1. Stay until `mem_ready`, then go to MEM_WB.
- MEM_WB: drives `reg_we`=1, `reg_dst`=0, `wb_sel`=01. Go to FETCH.
- MEM_WR: drives `mem_we`=1. Stay until `mem_ready`, then go to FETCH.
- BRANCH: drives `alu_src_a`=1, `alu_src_b`=00, `alu_sel`=01, `pc_src`=01, `pc_we` = `alu_zero`. Go to FETCH.
- JUMP: drives `pc_src`=10, `pc_we`=1. Go to FETCH.
- `retired` increments by 1 on the final cycle of each instruction, with wrap-around at 2^32:
  - WB without trap, MEM_WB, MEM_WR with `mem_ready`, BRANCH (taken or not), JUMP.
  - Never incremented for illegal or trapped instructions.

## Timing
- Reset (async, `rst_n`=0):
  - `state` = FETCH, `retired` = 0, `ovf_pending` = 0, `lt_q` = 0.
  - All enables 0, all selects 0.
  - Deasserting reset mid-instruction restarts at FETCH. Any partial memory access is abandoned.
- Cycle counts with `mem_ready` held at 1: R-type/ori 4, lw 5, sw 4, beq 3, j 3.
- Each cycle of `mem_ready`=0 in FETCH/MEM_RD/MEM_WR adds one cycle. Outputs stay stable while waiting.
- `mem_ready` is ignored in all other states.
- `ovf_exc` and `illegal` are high for exactly one cycle.
- `alu_*` inputs are sampled only at the rising edge ending EXEC_R, or combinationally in BRANCH.

## Test plan
- Reset, then addu with `mem_ready`=1:
  - `state` sequence 0,1,2,10,0.
  - `reg_we`=1 in WB with `reg_dst`=1, `wb_sel`=00.
  - `retired` goes 0→1.
- add with `alu_overflow`=1 in EXEC_R: WB shows `reg_we`=0 and `ovf_exc`=1 for one cycle; `retired` unchanged.
- lw with `mem_ready`=0 for 3 cycles in MEM_RD: 8 cycles total; MEM_WB has `reg_we`=1, `wb_sel`=01, `reg_dst`=0.
- beq:
  - `alu_zero`=1: `pc_we`=1, `pc_src`=01.
  - `alu_zero`=0: `pc_we`=0.
  - Both cases increment `retired`.
- `op`=111111: `illegal` pulses in DECODE, next state FETCH, `retired` unchanged.
- `rst_n` low in MEM_WR while `mem_ready`=0: immediate `state`=0, `mem_we`=0, `retired`=0.
